demux_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 1-to-4 demultiplexer between four destination requesters.
- Arbitrates the requests, grants one destination at a time for a bounded dwell window, and drives the demux select.
- Routes the 1-bit serial input to the granted output only, with a guard gap between grants.
- Sits in front of the demux datapath and replaces its free-running select.

---
 rtl/demux_rr_sched.sv | 133 +++++++++++++
 tb/tb_demux_rr_sched.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler sharing one 1-to-4 demux between four requesters.
// Grants one destination at a time for up to DWELL cycles, with GAP idle cycles between grants.
module demux_rr_sched #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned GAP   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       din,
    input  logic [3:0] req,
    input  logic [3:0] rel,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic [3:0] y,
    output logic       busy
);

    localparam int unsigned N_DEST = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned GCNT_W = 4;
    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(DWELL - 1);
    localparam logic [GCNT_W-1:0] GCNT_INIT = (GAP > 0) ? GCNT_W'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          gnt_q, gnt_d;
    logic [1:0]          sel_q, sel_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
    logic                busy_q, busy_d;

    logic                found;
    logic [1:0]          winner;
    logic [1:0]          idx;
    logic                leave_grant;

    // First set request searching ptr, ptr+1, ... modulo 4.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
        for (int i = 0; i < int'(N_DEST); i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign leave_grant = (cnt_q == '0) || rel[sel_q] || !req[sel_q] || !en;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            S_IDLE: begin
                gnt_d = 4'b0000;
                if (en && found) begin
                    state_d = S_GRANT;
                    sel_d   = winner;
                    gnt_d   = 4'b0001 << winner;
                    cnt_d   = CNT_INIT;
                end
            end
            S_GRANT: begin
                if (leave_grant) begin
                    // Advancing ptr past the holder keeps it from winning while others wait.
                    gnt_d = 4'b0000;
                    ptr_d = sel_q + 2'd1;
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        gcnt_d  = GCNT_INIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                gnt_d = 4'b0000;
                if (gcnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q - GCNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;
    assign y    = {4{din}} & gnt_q;

endmodule

// File: tb/tb_demux_rr_sched.sv
// Directed bench for demux_rr_sched: rotation, routing, early release, fairness, drop/enable, async reset.
module tb_demux_rr_sched;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       din;
    logic [3:0] req;
    logic [3:0] rel;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic [3:0] y;
    logic       busy;

    logic [3:0] req2;
    logic [3:0] rel2;
    logic [1:0] sel2;
    logic [3:0] gnt2;
    logic [3:0] y2;
    logic       busy2;

    int checks;
    int passes;

    demux_rr_sched #(.DWELL(4), .GAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .req(req), .rel(rel),
        .sel(sel), .gnt(gnt), .y(y), .busy(busy)
    );

    demux_rr_sched #(.DWELL(2), .GAP(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .req(req2), .rel(rel2),
        .sel(sel2), .gnt(gnt2), .y(y2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end else begin
            passes++;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [3:0] fair_exp [14];

    initial begin
        checks = 0;
        passes = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        en    = 1'b1;
        din   = 1'b1;
        req   = 4'b1111;
        rel   = 4'b0000;
        req2  = 4'b0000;
        rel2  = 4'b0000;

        // Reset state
        cyc(2);
        chk("rst_gnt", 8'(gnt), 8'h0);
        chk("rst_sel", 8'(sel), 8'h0);
        chk("rst_y", 8'(y), 8'h0);
        chk("rst_busy", 8'(busy), 8'h0);

        // Rotation with DWELL=4, GAP=1
        rst_n = 1'b1;
        cyc(1);
        chk("rot_g0_first", 8'(gnt), 8'h1);
        chk("rot_busy", 8'(busy), 8'h1);
        chk("rot_y0", 8'(y), 8'h1);
        cyc(3);
        chk("rot_g0_last", 8'(gnt), 8'h1);
        cyc(1);
        chk("rot_gap_gnt", 8'(gnt), 8'h0);
        chk("rot_gap_busy", 8'(busy), 8'h1);
        cyc(1);
        chk("rot_idle_gnt", 8'(gnt), 8'h0);
        chk("rot_idle_busy", 8'(busy), 8'h0);
        cyc(1);
        chk("rot_g1", 8'(gnt), 8'h2);
        chk("rot_sel1", 8'(sel), 8'h1);
        cyc(6);
        chk("rot_g2", 8'(gnt), 8'h4);
        chk("rot_sel2", 8'(sel), 8'h2);

        // Routing during the 0100 grant
        din = 1'b1; #1;
        chk("route_d1", 8'(y), 8'h4);
        din = 1'b0; #1;
        chk("route_d0", 8'(y), 8'h0);
        din = 1'b1; #1;
        chk("route_d1b", 8'(y), 8'h4);
        rel = 4'b0001;
        cyc(1);
        rel = 4'b0000;
        chk("rel_other_ignored", 8'(gnt), 8'h4);
        cyc(5);
        chk("rot_g3", 8'(gnt), 8'h8);
        chk("rot_sel3", 8'(sel), 8'h3);
        cyc(6);
        chk("rot_wrap", 8'(gnt), 8'h1);

        // Early release of a 0010 grant on its 2nd cycle
        rst_n = 1'b0;
        req   = 4'b0010;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        chk("er_g1", 8'(gnt), 8'h2);
        cyc(1);
        rel = 4'b0010;
        cyc(1);
        rel = 4'b0000;
        chk("er_gnt0", 8'(gnt), 8'h0);
        chk("er_busy", 8'(busy), 8'h1);
        req = 4'b0111;
        cyc(1);
        chk("er_idle_busy", 8'(busy), 8'h0);
        cyc(1);
        chk("er_ptr2", 8'(gnt), 8'h4);

        // Requester drops mid-grant
        req = 4'b0011;
        cyc(1);
        chk("drop_gnt", 8'(gnt), 8'h0);
        chk("drop_busy", 8'(busy), 8'h1);

        // en=0 blocks arbitration in IDLE
        en  = 1'b0;
        req = 4'b1000;
        cyc(1);
        chk("en0_gnt_a", 8'(gnt), 8'h0);
        cyc(2);
        chk("en0_gnt_b", 8'(gnt), 8'h0);
        chk("en0_busy", 8'(busy), 8'h0);
        en = 1'b1;
        cyc(1);
        chk("en1_gnt", 8'(gnt), 8'h8);

        // Async reset mid-grant (cnt=2)
        cyc(1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt", 8'(gnt), 8'h0);
        chk("arst_sel", 8'(sel), 8'h0);
        chk("arst_busy", 8'(busy), 8'h0);
        chk("arst_y", 8'(y), 8'h0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        chk("arst_regrant", 8'(gnt), 8'h8);
        chk("arst_sel3", 8'(sel), 8'h3);

        // Fairness on the DWELL=2 instance with req=0011 held
        req   = 4'b0000;
        rst_n = 1'b0;
        req2  = 4'b0011;
        fair_exp = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0,
                     4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2};
        cyc(1);
        chk("fair_rst", 8'(gnt2), 8'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cyc(1);
            chk($sformatf("fair_c%0d", i + 1), 8'(gnt2), 8'(fair_exp[i]));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
